nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder_pkg.sv | 12 +
 rtl/nibble_serial_adder_add4.sv | 23 ++
 rtl/nibble_serial_adder.sv | 99 +++++++++
 tb/tb_nibble_serial_adder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and control state encoding.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_add4.sv
// Purely combinational 4-bit ripple-carry slice built from four one-bit full-adder cells.
module nibble_add4
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    logic [NIBBLE_W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: feeds one operand nibble per clock (LSN first) through a
// 4-bit ripple slice, keeping the inter-nibble carry in a register.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NIBBLES = WIDTH / NIBBLE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t            state;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-1:0]  res;
    logic [WIDTH-1:0]  res_next;
    logic              carry;
    logic              cout_r;
    logic [IDXW-1:0]   idx;
    logic [NIBBLE_W-1:0] s4;
    logic              c4;

    nibble_add4 u_slice (
        .x  (a_sh[NIBBLE_W-1:0]),
        .y  (b_sh[NIBBLE_W-1:0]),
        .ci (carry),
        .s  (s4),
        .co (c4)
    );

    // New sum nibble enters at the top so the LSN ends up at the bottom after NIBBLES shifts.
    if (WIDTH == NIBBLE_W) begin : g_res_single
        assign res_next = s4;
    end else begin : g_res_shift
        assign res_next = {s4, res[WIDTH-1:NIBBLE_W]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            idx    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    res   <= res_next;
                    a_sh  <= a_sh >> NIBBLE_W;
                    b_sh  <= b_sh >> NIBBLE_W;
                    carry <= c4;
                    idx   <= idx + IDXW'(1);
                    if (idx == IDXW'(NIBBLES - 1)) begin
                        cout_r <= c4;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshake flags depend only on state (and are held low during reset).
    assign in_ready  = !rst && (state == ST_IDLE);
    assign out_valid = !rst && (state == ST_DONE);
    assign busy      = !rst && ((state == ST_RUN) || (state == ST_DONE));
    assign sum       = res;
    assign cout      = cout_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomised checks of nibble_serial_adder at WIDTH=16 and WIDTH=4.
module tb_nibble_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        in_valid16, in_ready16, cin16, out_valid16, out_ready16, cout16, busy16;
    logic [15:0] a16, b16, sum16;

    logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, busy4;
    logic [3:0]  a4, b4, sum4;

    int tests = 0;
    int fails = 0;

    nibble_serial_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16), .busy(busy16)
    );

    nibble_serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic op16(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                        input logic xc, input logic [15:0] es, input logic ec, input bit pop);
        int lat;
        check({tag, "_in_ready_idle"}, 32'(in_ready16), 32'd1);
        a16 = xa; b16 = xb; cin16 = xc; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        lat = 0;
        while (!out_valid16 && lat < 20) begin
            check({tag, "_in_ready_run"}, 32'(in_ready16), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_sum"}, 32'(sum16), 32'(es));
        check({tag, "_cout"}, 32'(cout16), 32'(ec));
        check({tag, "_busy"}, 32'(busy16), 32'd1);
        if (pop) begin
            out_ready16 = 1'b1;
            @(posedge clk); #1;
            out_ready16 = 1'b0;
            check({tag, "_pop_valid"}, 32'(out_valid16), 32'd0);
            check({tag, "_pop_ready"}, 32'(in_ready16), 32'd1);
        end
    endtask

    task automatic op4(input string tag, input logic [3:0] xa, input logic [3:0] xb,
                       input logic xc, input logic [3:0] es, input logic ec);
        int lat;
        check({tag, "_in_ready_idle"}, 32'(in_ready4), 32'd1);
        a4 = xa; b4 = xb; cin4 = xc; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd1);
        check({tag, "_sum"}, 32'(sum4), 32'(es));
        check({tag, "_cout"}, 32'(cout4), 32'(ec));
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        check({tag, "_pop_ready"}, 32'(in_ready4), 32'd1);
    endtask

    initial begin
        logic [16:0] q[$];
        logic [16:0] e;
        int acc, got, cyc;

        rst = 1'b1;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; out_ready16 = 1'b0;
        in_valid4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0; out_ready4  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready16), 32'd0);
        check("rst_out_valid", 32'(out_valid16), 32'd0);
        check("rst_busy", 32'(busy16), 32'd0);
        check("rst_sum", 32'(sum16), 32'd0);
        check("rst_cout", 32'(cout16), 32'd0);
        check("rst_in_ready4", 32'(in_ready4), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(in_ready16), 32'd1);
        check("post_rst_busy", 32'(busy16), 32'd0);

        op16("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b1);
        op16("carry_b", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
        op16("carry_cin", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1);
        op16("msb_ovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        op16("mixed", 16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b1);

        // Backpressure: result must hold while in_valid toggles and out_ready stays low.
        op16("bp", 16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0);
        a16 = 16'h1111; b16 = 16'h2222;
        for (int i = 0; i < 5; i++) begin
            in_valid16 = ~in_valid16;
            @(posedge clk); #1;
            check("bp_valid", 32'(out_valid16), 32'd1);
            check("bp_sum", 32'(sum16), 32'h0100);
            check("bp_in_ready", 32'(in_ready16), 32'd0);
        end
        in_valid16 = 1'b0;
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;
        check("bp_pop_ready", 32'(in_ready16), 32'd1);
        check("bp_pop_valid", 32'(out_valid16), 32'd0);
        check("bp_pop_busy", 32'(busy16), 32'd0);

        // Reset two cycles into RUN aborts the operation.
        a16 = 16'hABCD; b16 = 16'h1111; cin16 = 1'b0; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("abort_busy_pre", 32'(busy16), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_valid", 32'(out_valid16), 32'd0);
        check("abort_busy", 32'(busy16), 32'd0);
        check("abort_sum", 32'(sum16), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_in_ready", 32'(in_ready16), 32'd1);
        op16("after_abort", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b1);

        op4("w4_a", 4'h9, 4'h8, 1'b0, 4'h1, 1'b1);
        op4("w4_b", 4'h7, 4'h8, 1'b1, 4'h0, 1'b1);
        op4("w4_c", 4'h3, 4'h4, 1'b0, 4'h7, 1'b0);

        // Random traffic against a behavioural a+b+cin model.
        acc = 0; got = 0; cyc = 0;
        while (got < 1000 && cyc < 60000) begin
            in_valid16  = (acc < 1000) && ($urandom_range(0, 1) == 1);
            a16         = 16'($urandom);
            b16         = 16'($urandom);
            cin16       = 1'($urandom_range(0, 1));
            out_ready16 = ($urandom_range(0, 1) == 1);
            if (in_valid16 && in_ready16) begin
                q.push_back({1'b0, a16} + {1'b0, b16} + 17'(cin16));
                acc++;
            end
            if (out_valid16 && out_ready16) begin
                check("rand_nodup", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("rand_result", 32'({cout16, sum16}), 32'(e));
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid16 = 1'b0;
        out_ready16 = 1'b0;
        check("rand_count", 32'(got), 32'd1000);
        check("rand_lost", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
